// File: rtl/mem_ctrl_pkg.sv
// Shared types, FSM encodings and byte helpers for the byte-serial RAM port controller.
package mem_ctrl_pkg;

  localparam int MC_ADDR_WIDTH = 32;
  localparam int MC_MAX_BYTES  = 4;

  localparam logic [2:0] MC_IDLE   = 3'd0;
  localparam logic [2:0] MC_IF_RD  = 3'd1;
  localparam logic [2:0] MC_MEM_RD = 3'd2;
  localparam logic [2:0] MC_MEM_WR = 3'd3;
  localparam logic [2:0] MC_DONE   = 3'd4;

  typedef logic [2:0]  mem_len_t;
  typedef logic [7:0]  ram_data_t;
  typedef logic [31:0] word_t;

  // Only 1, 2 and 4 byte accesses exist; anything else becomes a full word.
  function automatic mem_len_t norm_len(input mem_len_t len, input mem_len_t full_len);
    case (len)
      3'd1, 3'd2, 3'd4: return len;
      default:          return full_len;
    endcase
  endfunction

  function automatic ram_data_t word_byte(input word_t w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline (IF/MEM) and RAM side signals of the memory controller; the controller is the slave.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = MC_ADDR_WIDTH
) ();

  logic                  if_req_i;
  logic [ADDR_WIDTH-1:0] if_addr_i;
  logic                  if_flush_i;
  word_t                 if_inst_o;
  logic                  if_done_o;

  logic                  mem_req_i;
  logic                  mem_we_i;
  mem_len_t              mem_len_i;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  word_t                 mem_wdata_i;
  word_t                 mem_rdata_o;
  logic                  mem_done_o;

  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic                  ram_wr_o;
  ram_data_t             ram_dout_o;
  ram_data_t             ram_din_i;

  logic                  stall_req_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_inst_o, if_done_o,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_done_o,
    output ram_addr_o, ram_wr_o, ram_dout_o,
    input  ram_din_i,
    output stall_req_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_inst_o, if_done_o,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_done_o,
    input  ram_addr_o, ram_wr_o, ram_dout_o,
    output ram_din_i,
    input  stall_req_o
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM port between fetch and load/store, one byte per cycle (word read done at T+6, word store at T+5).
// No backpressure beyond holding req: requests are sampled only in IDLE, MEM wins, and stall_req_o covers a pending MEM access.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = MC_ADDR_WIDTH,
  parameter int MAX_BYTES  = MC_MAX_BYTES
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  localparam mem_len_t FULL_LEN = mem_len_t'(MAX_BYTES);

  logic [2:0]            r_state;
  mem_len_t              r_cnt;
  mem_len_t              r_len;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_is_if;
  word_t                 r_wdata;
  word_t                 r_data;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  ram_data_t             r_ram_dout;

  logic                  w_reading;
  logic                  w_writing;
  logic                  w_issue;
  logic                  w_if_flush;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [1:0]            w_cap_idx;
  ram_data_t             w_wr_byte;

  assign w_reading  = (r_state == MC_IF_RD) || (r_state == MC_MEM_RD);
  assign w_writing  = (r_state == MC_MEM_WR);
  assign w_done     = (r_state == MC_DONE);
  assign w_issue    = w_reading && (r_cnt < r_len);
  assign w_addr     = r_base + ADDR_WIDTH'(r_cnt);
  assign w_cap_idx  = 2'(r_cnt - 3'd1);
  assign w_wr_byte  = word_byte(r_wdata, r_cnt[1:0]);
  assign w_if_flush = bus.if_flush_i && r_is_if && ((r_state == MC_IF_RD) || w_done);

  // Address and write byte are live while sequencing, otherwise they hold the last driven value.
  assign bus.ram_wr_o    = w_writing;
  assign bus.ram_addr_o  = (w_issue || w_writing) ? w_addr : r_ram_addr;
  assign bus.ram_dout_o  = w_writing ? w_wr_byte : r_ram_dout;

  assign bus.if_done_o   = w_done && r_is_if && !bus.if_flush_i;
  assign bus.mem_done_o  = w_done && !r_is_if;
  assign bus.if_inst_o   = r_data;
  assign bus.mem_rdata_o = r_data;
  assign bus.stall_req_o = bus.mem_req_i && !(w_done && !r_is_if);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MC_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_base     <= '0;
      r_is_if    <= 1'b0;
      r_wdata    <= '0;
      r_data     <= '0;
      r_ram_addr <= '0;
      r_ram_dout <= '0;
    end else begin
      if (w_issue || w_writing) begin
        r_ram_addr <= w_addr;
      end
      case (r_state)
        MC_IDLE: begin
          r_cnt <= '0;
          if (bus.mem_req_i) begin
            r_base  <= bus.mem_addr_i;
            r_len   <= norm_len(bus.mem_len_i, FULL_LEN);
            r_wdata <= bus.mem_wdata_i;
            r_is_if <= 1'b0;
            r_data  <= '0;
            r_state <= bus.mem_we_i ? MC_MEM_WR : MC_MEM_RD;
          end else if (bus.if_req_i) begin
            r_base  <= bus.if_addr_i;
            r_len   <= FULL_LEN;
            r_is_if <= 1'b1;
            r_data  <= '0;
            r_state <= MC_IF_RD;
          end
        end
        MC_IF_RD, MC_MEM_RD: begin
          if (w_if_flush) begin
            r_data  <= '0;
            r_state <= MC_IDLE;
          end else begin
            // RAM returns the byte addressed in the previous cycle.
            if (r_cnt != 3'd0) begin
              r_data[{w_cap_idx, 3'b000} +: 8] <= bus.ram_din_i;
            end
            if (r_cnt == r_len) begin
              r_state <= MC_DONE;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        MC_MEM_WR: begin
          r_ram_dout <= w_wr_byte;
          if (r_cnt == r_len - 3'd1) begin
            r_state <= MC_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        MC_DONE: begin
          r_cnt   <= '0;
          r_state <= MC_IDLE;
        end
        default: begin
          r_state <= MC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table, hand-written corner sequences and randomized traffic against a byte-array model.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32), .MAX_BYTES(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] ram  [logic [31:0]];
  logic [7:0] refm [logic [31:0]];

  typedef struct {
    bit          is_if;
    bit          we;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [10];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : dflt(a);
  endfunction

  function automatic int norm(input logic [2:0] len);
    return (len == 3'd1 || len == 3'd2 || len == 3'd4) ? int'(len) : 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = w | (32'(ref_rd(a + 32'(i))) << (8 * i));
    return w;
  endfunction

  // Byte-wide synchronous RAM: one cycle read latency, write on strobe.
  always @(posedge clk) begin
    if (bus.ram_wr_o === 1'b1) ram[bus.ram_addr_o] = bus.ram_dout_o;
    bus.ram_din_i <= ram_rd(bus.ram_addr_o);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preset(input logic [31:0] a, input logic [7:0] d);
    ram[a]  = d;
    refm[a] = d;
  endtask

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wdata);
    logic [31:0] sh;
    for (int i = 0; i < n; i++) begin
      sh = wdata >> (8 * i);
      refm[a + 32'(i)] = sh[7:0];
    end
  endtask

  task automatic idle_inputs();
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.if_flush_i  = 1'b0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_len_i   = '0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
  endtask

  // One request from IDLE; checks address/write/stall protocol each cycle and returns latency and data.
  task automatic xact(input string tag, input bit is_if, input bit we, input logic [2:0] len,
                      input logic [31:0] addr, input logic [31:0] wdata, input int flush_k,
                      output int lat, output logic [31:0] data);
    int n, bad_addr, bad_wr, n_wr, bad_stall, bad_other;
    bit st;
    logic [31:0] exp_a, sh;
    n  = is_if ? 4 : norm(len);
    st = we && !is_if;
    bad_addr = 0; bad_wr = 0; n_wr = 0; bad_stall = 0; bad_other = 0;
    lat = -1; data = '0;
    @(negedge clk);
    if (is_if) begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
    end else begin
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_len_i   = len;
      bus.mem_addr_i  = addr;
      bus.mem_wdata_i = wdata;
    end
    bus.if_flush_i = (flush_k == 0);
    for (int k = 1; k <= 24 && lat < 0; k++) begin
      @(negedge clk);
      exp_a = addr + 32'((k <= n) ? k - 1 : n - 1);
      if (bus.ram_addr_o !== exp_a) bad_addr++;
      if (bus.ram_wr_o !== 1'b0) begin
        n_wr++;
        sh = wdata >> (8 * (k - 1));
        if (!st || k > n || bus.ram_dout_o !== sh[7:0]) bad_wr++;
      end
      if (!is_if && bus.stall_req_o !== !bus.mem_done_o) bad_stall++;
      if ((is_if ? bus.mem_done_o : bus.if_done_o) !== 1'b0) bad_other++;
      if ((is_if ? bus.if_done_o : bus.mem_done_o) === 1'b1) begin
        lat  = k;
        data = is_if ? bus.if_inst_o : bus.mem_rdata_o;
        bus.if_req_i  = 1'b0;
        bus.mem_req_i = 1'b0;
      end
      bus.if_flush_i = (k == flush_k);
    end
    bus.if_req_i   = 1'b0;
    bus.mem_req_i  = 1'b0;
    bus.if_flush_i = 1'b0;
    chk({tag, " addr seq"}, bad_addr, 0);
    chk({tag, " write strobes"}, n_wr, st ? n : 0);
    chk({tag, " write bytes"}, bad_wr, 0);
    if (!is_if) chk({tag, " stall"}, bad_stall, 0);
    chk({tag, " other done"}, bad_other, 0);
  endtask

  task automatic model_xact(input string tag, input bit is_if, input bit we, input logic [2:0] len,
                            input logic [31:0] addr, input logic [31:0] wdata, input int flush_k);
    int n, lat;
    bit st;
    logic [31:0] exp_d, d;
    n     = is_if ? 4 : norm(len);
    st    = we && !is_if;
    exp_d = ref_word(addr, n);
    xact(tag, is_if, we, len, addr, wdata, flush_k, lat, d);
    chk({tag, " latency"}, lat, st ? n + 1 : n + 2);
    if (st) ref_store(addr, n, wdata);
    else    chk({tag, " data"}, d, exp_d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, mdone, idone, bad, a1, a8;
    logic [31:0] d, md, id, e2;
    logic [31:0] rnd_addr;
    logic [2:0] lens [8];

    preset(32'h1000, 8'h13); preset(32'h1001, 8'h00);
    preset(32'h1002, 8'h50); preset(32'h1003, 8'h00);
    preset(32'hFFFF_FFFF, 8'h80); preset(32'hFFFF_FFFE, 8'h11);
    preset(32'h0000_0000, 8'h22); preset(32'h0000_0001, 8'h33);

    vt[0] = '{1'b1, 1'b0, 3'd4, 32'h0000_1000, 32'h0,          6, 32'h0050_0013};
    vt[1] = '{1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'hAABB_CCDD,  3, 32'h0};
    vt[2] = '{1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0,          4, 32'h0000_CCDD};
    vt[3] = '{1'b0, 1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0,          3, 32'h0000_0080};
    vt[4] = '{1'b0, 1'b0, 3'd4, 32'hFFFF_FFFE, 32'h0,          6, 32'h3322_8011};
    vt[5] = '{1'b0, 1'b1, 3'd7, 32'h0000_0040, 32'h0102_0304,  5, 32'h0};
    vt[6] = '{1'b0, 1'b0, 3'd0, 32'h0000_0040, 32'h0,          6, 32'h0102_0304};
    vt[7] = '{1'b0, 1'b0, 3'd1, 32'h0000_0042, 32'h0,          3, 32'h0000_0002};
    vt[8] = '{1'b0, 1'b1, 3'd1, 32'h0000_0043, 32'hFFFF_FF9C,  2, 32'h0};
    vt[9] = '{1'b0, 1'b0, 3'd4, 32'h0000_0040, 32'h0,          6, 32'h9C02_0304};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ram_wr", bus.ram_wr_o, 0);
    chk("reset ram_addr", bus.ram_addr_o, 0);
    chk("reset ram_dout", bus.ram_dout_o, 0);
    chk("reset dones", {bus.if_done_o, bus.mem_done_o, bus.stall_req_o}, 0);
    chk("reset if_inst", bus.if_inst_o, 0);
    chk("reset mem_rdata", bus.mem_rdata_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      xact($sformatf("vec%0d", i), vt[i].is_if, vt[i].we, vt[i].len, vt[i].addr, vt[i].wdata, -1, lat, d);
      chk($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
      if (vt[i].we) ref_store(vt[i].addr, norm(vt[i].len), vt[i].wdata);
      else chk($sformatf("vec%0d data", i), d, vt[i].exp_data);
    end

    // IF and MEM in the same IDLE cycle: MEM first, IF in the IDLE after DONE.
    e2 = ref_word(32'h2000, 4);
    mdone = -1; idone = -1; bad = 0; a1 = 0; a8 = 0; md = '0; id = '0;
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1000;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 3'd4; bus.mem_addr_i = 32'h2000;
    for (int k = 1; k <= 30 && idone < 0; k++) begin
      @(negedge clk);
      if (k == 1) a1 = int'(bus.ram_addr_o);
      if (k == 8) a8 = int'(bus.ram_addr_o);
      if (mdone < 0 && bus.mem_done_o === 1'b1) begin
        mdone = k; md = bus.mem_rdata_o; bus.mem_req_i = 1'b0;
      end else if (mdone < 0 && bus.stall_req_o !== 1'b1) bad++;
      if (bus.if_done_o === 1'b1) begin
        idone = k; id = bus.if_inst_o; bus.if_req_i = 1'b0;
      end
    end
    idle_inputs();
    chk("prio mem first addr", a1, 32'h2000);
    chk("prio mem done", mdone, 6);
    chk("prio mem data", md, e2);
    chk("prio stall held", bad, 0);
    chk("prio if addr", a8, 32'h1000);
    chk("prio if done", idone, 13);
    chk("prio if data", id, 32'h0050_0013);

    // Flush at T+3 aborts the fetch; a new fetch is accepted at T+4.
    idone = -1; bad = 0; a1 = 0; id = '0;
    @(negedge clk);
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h3000;
    for (int k = 1; k <= 20 && idone < 0; k++) begin
      @(negedge clk);
      if (k == 5) a1 = int'(bus.ram_addr_o);
      if (bus.if_done_o === 1'b1) begin
        idone = k; id = bus.if_inst_o; bus.if_req_i = 1'b0;
      end
      if (k == 3) bus.if_flush_i = 1'b1;
      if (k == 4) begin
        bus.if_flush_i = 1'b0;
        bus.if_addr_i  = 32'h1000;
      end
    end
    idle_inputs();
    chk("flush refetch addr", a1, 32'h1000);
    chk("flush done cycle", idone, 10);
    chk("flush refetch data", id, 32'h0050_0013);

    // Flush in IDLE is ignored; flush never touches MEM accesses.
    model_xact("flush idle", 1'b1, 1'b0, 3'd4, 32'h1000, 32'h0, 0);
    model_xact("flush mem rd", 1'b0, 1'b0, 3'd4, 32'h0040, 32'h0, 2);
    model_xact("flush mem wr", 1'b0, 1'b1, 3'd4, 32'h0060, 32'hCAFE_F00D, 1);

    // Reset during a word store at c=1.
    mdone = 0;
    @(negedge clk);
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 3'd4;
    bus.mem_addr_i = 32'h50; bus.mem_wdata_i = 32'h1122_3344;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid wr before", {bus.ram_wr_o, bus.ram_addr_o[7:0], bus.ram_dout_o}, {1'b1, 8'h51, 8'h33});
    rst = 1'b1;
    bus.mem_req_i = 1'b0;
    @(negedge clk);
    chk("rstmid ram_wr", bus.ram_wr_o, 0);
    chk("rstmid ram_addr", bus.ram_addr_o, 0);
    chk("rstmid ram_dout", bus.ram_dout_o, 0);
    chk("rstmid outputs", {bus.if_done_o, bus.mem_done_o, bus.stall_req_o, bus.mem_rdata_o | bus.if_inst_o}, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.mem_done_o !== 1'b0 || bus.ram_wr_o !== 1'b0) mdone++;
    end
    chk("rstmid no done", mdone, 0);
    refm[32'h50] = 8'h44;
    refm[32'h51] = 8'h33;
    model_xact("rstmid reload", 1'b0, 1'b0, 3'd4, 32'h50, 32'h0, -1);
    model_xact("rstmid restore", 1'b0, 1'b1, 3'd4, 32'h50, 32'h5566_7788, -1);
    model_xact("rstmid readback", 1'b0, 1'b0, 3'd4, 32'h50, 32'h0, -1);

    lens = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd3, 3'd0, 3'd7, 3'd2};
    for (int i = 0; i < 40; i++) begin
      bit r_if, r_we;
      int fk;
      r_if = ($urandom_range(0, 3) == 0);
      r_we = r_if ? 1'b0 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) rnd_addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else rnd_addr = 32'h100 + 32'($urandom_range(0, 63));
      fk = (!r_if && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : -1;
      model_xact($sformatf("rand%0d", i), r_if, r_we, lens[$urandom_range(0, 7)],
                 rnd_addr, $urandom, fk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
